// File: rtl/uart_rx_deserialise_if.sv
// Byte delivery handshake between the UART receiver and its downstream consumer.
// The receiver is the master: it drives rx_byte/valid and observes ready.
interface uart_rx_deserialise_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_byte;
   logic                 valid;
   logic                 ready;

   modport master (output rx_byte, output valid, input ready);
   modport slave  (input rx_byte, input valid, output ready);
endinterface

// File: rtl/uart_rx_deserialise.sv
// UART receiver: synchronises rx_bits_i, samples mid-bit on clk, delivers bytes over valid/ready.
// Optional even parity checking is enabled by defining UART_RX_PARITY_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | line idle, waiting for a low on the synchronised input
// START   | half a bit into the start bit, confirm it is still low
// DATA    | sample DATA_BITS data bits, LSB first
// PARITY  | sample the even parity bit (UART_RX_PARITY_EN only)
// STOP    | sample STOP_BITS stop bits, deliver byte after the last
// BREAK   | stop bit read low, hold off until the line returns high
module uart_rx_deserialise #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int CLK_RATE  = 12000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rx_bits_i,
   uart_rx_deserialise_if.master  rx_if,
   output logic                   frame_err_o,
`ifdef UART_RX_PARITY_EN
   output logic                   parity_err_o,
`endif
   output logic                   overrun_o
);

   localparam int DIVISOR = CLK_RATE / BAUD_RATE;
   localparam int HALF    = DIVISOR / 2;
   localparam int TW      = $clog2(DIVISOR);
   localparam int CW      = $clog2(DATA_BITS + STOP_BITS + 1);

   localparam logic [TW-1:0] T_LAST = TW'(DIVISOR - 1);
   localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
   localparam logic [CW-1:0] D_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] S_LAST = CW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state_q;
   logic                 rx_meta_q;
   logic                 rx_s_q;
   logic [TW-1:0]        timer_q;
   logic [CW-1:0]        bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 deliver_q;
   logic [DATA_BITS-1:0] rx_byte_q;
   logic                 valid_q;
   logic                 frame_err_q;
   logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q;
   logic                 parity_err_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         timer_q     <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         deliver_q   <= 1'b0;
         rx_byte_q   <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_meta_q   <= rx_bits_i;
         rx_s_q      <= rx_meta_q;
         deliver_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif

         case (state_q)
            S_IDLE: begin
               timer_q <= '0;
               if (!rx_s_q) state_q <= S_START;
            end

            S_START: begin
               if (timer_q == T_HALF) begin
                  timer_q   <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            S_DATA: begin
               if (timer_q == T_LAST) begin
                  timer_q <= '0;
                  shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == D_LAST) begin
                     bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                     state_q   <= S_PARITY;
`else
                     state_q   <= S_STOP;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (timer_q == T_LAST) begin
                  timer_q      <= '0;
                  par_bad_q    <= (^shift_q) ^ rx_s_q;
                  parity_err_q <= (^shift_q) ^ rx_s_q;
                  state_q      <= S_STOP;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (timer_q == T_LAST) begin
                  timer_q <= '0;
                  if (!rx_s_q) begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_BREAK;
                  end else if (bit_cnt_q == S_LAST) begin
`ifdef UART_RX_PARITY_EN
                     deliver_q <= !par_bad_q;
`else
                     deliver_q <= 1'b1;
`endif
                     state_q   <= S_IDLE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            S_BREAK: begin
               timer_q <= '0;
               if (rx_s_q) state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase

         // A delivery coinciding with an acceptance refills the holding register.
         if (deliver_q) begin
            if (!valid_q || rx_if.ready) begin
               rx_byte_q <= shift_q;
               valid_q   <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && rx_if.ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_if.rx_byte = rx_byte_q;
   assign rx_if.valid   = valid_q;
   assign frame_err_o   = frame_err_q;
   assign overrun_o     = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err_o  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserialise.sv
// Directed bench for uart_rx_deserialise at DIVISOR=16, HALF=8.
module tb_uart_rx_deserialise;

`ifdef UART_RX_PARITY_EN
   localparam int LAT = 2 + 8 + 10 * 16 + 1;
`else
   localparam int LAT = 2 + 8 + 9 * 16 + 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_bits = 1'b1;
   logic frame_err;
   logic overrun;
`ifdef UART_RX_PARITY_EN
   logic parity_err;
`endif

   uart_rx_deserialise_if #(.DATA_BITS(8)) u_if ();

   uart_rx_deserialise #(
      .DATA_BITS(8),
      .STOP_BITS(1),
      .CLK_RATE (1600000),
      .BAUD_RATE(100000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_bits_i   (rx_bits),
      .rx_if       (u_if),
      .frame_err_o (frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err_o(parity_err),
`endif
      .overrun_o   (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled on the falling edge.
   logic       valid_prev = 1'b0;
   int         valid_hi_n = 0;
   int         ferr_n = 0;
   int         ovr_n = 0;
   int         last_rise_cyc = 0;
   int         last_ovr_cyc = 0;
   logic [7:0] acc_q[$];

   always @(negedge clk) begin
      if (u_if.valid && !valid_prev) last_rise_cyc = cyc;
      valid_prev = u_if.valid;
      if (u_if.valid) valid_hi_n++;
      if (u_if.valid && u_if.ready) acc_q.push_back(u_if.rx_byte);
      if (frame_err) ferr_n++;
      if (overrun) begin
         ovr_n++;
         last_ovr_cyc = cyc;
      end
   end

   int n_pass = 0;
   int n_total = 0;
   int start_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      rx_bits = 1'b1;
      tick(n);
   endtask

   // Called #1 after a rising edge; drives one full frame, 16 cycles per bit.
   task automatic send_frame(input logic [7:0] d, input logic stop_b, input int hold_low);
      rx_bits   = 1'b0;
      start_cyc = cyc + 1;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         rx_bits = d[i];
         tick(16);
      end
`ifdef UART_RX_PARITY_EN
      rx_bits = ^d;
      tick(16);
`endif
      rx_bits = stop_b;
      tick(16);
      if (hold_low > 0) begin
         rx_bits = 1'b0;
         tick(hold_low);
      end
      rx_bits = 1'b1;
   endtask

   function automatic logic [31:0] acc_at(input int idx);
      if (acc_q.size() > idx) return {24'h0, acc_q[idx]};
      return 32'hDEAD;
   endfunction

   typedef struct {
      logic [7:0] data;
      logic       stop_b;
      int         hold_low;
      logic       exp_valid;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[5];
   int a0, f0, o0, h0, start2;

   initial begin
      vecs[0] = '{data: 8'hA5, stop_b: 1'b1, hold_low: 0,  exp_valid: 1'b1, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'h12, stop_b: 1'b0, hold_low: 40, exp_valid: 1'b0, exp_ferr: 1'b1};
      vecs[2] = '{data: 8'h3C, stop_b: 1'b1, hold_low: 0,  exp_valid: 1'b1, exp_ferr: 1'b0};
      vecs[3] = '{data: 8'h81, stop_b: 1'b1, hold_low: 0,  exp_valid: 1'b1, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'h00, stop_b: 1'b1, hold_low: 0,  exp_valid: 1'b1, exp_ferr: 1'b0};

      u_if.ready = 1'b1;
      #1;
      chk("reset_valid",     32'(u_if.valid),   32'h0);
      chk("reset_rx_byte",   32'(u_if.rx_byte), 32'h0);
      chk("reset_frame_err", 32'(frame_err),    32'h0);
      chk("reset_overrun",   32'(overrun),      32'h0);

      tick(3);
      rst_n = 1'b1;
      idle(5);

      for (int i = 0; i < 5; i++) begin
         a0 = acc_q.size(); f0 = ferr_n; o0 = ovr_n; h0 = valid_hi_n;
         send_frame(vecs[i].data, vecs[i].stop_b, vecs[i].hold_low);
         idle(200);
         chk($sformatf("vec%0d_accepts", i),  32'(acc_q.size() - a0), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_valid_hi", i), 32'(valid_hi_n - h0),   32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_frame_err", i), 32'(ferr_n - f0),      32'(vecs[i].exp_ferr));
         chk($sformatf("vec%0d_overrun", i),  32'(ovr_n - o0),        32'h0);
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d_byte", i),    acc_at(a0),                      32'(vecs[i].data));
            chk($sformatf("vec%0d_latency", i), 32'(last_rise_cyc - start_cyc),  32'(LAT));
         end
      end

      // Short low glitch is rejected; a frame right after still decodes.
      a0 = acc_q.size(); f0 = ferr_n;
      rx_bits = 1'b0;
      tick(5);
      idle(12);
      chk("glitch_valid", 32'(u_if.valid), 32'h0);
      chk("glitch_accepts", 32'(acc_q.size() - a0), 32'h0);
      send_frame(8'h3C, 1'b1, 0);
      idle(200);
      chk("post_glitch_accepts", 32'(acc_q.size() - a0), 32'h1);
      chk("post_glitch_byte", acc_at(a0), 32'h3C);
      chk("post_glitch_latency", 32'(last_rise_cyc - start_cyc), 32'(LAT));
      chk("glitch_frame_err", 32'(ferr_n - f0), 32'h0);

      // Back-to-back frames with no idle gap.
      a0 = acc_q.size(); f0 = ferr_n; o0 = ovr_n;
      send_frame(8'h55, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      send_frame(8'h00, 1'b1, 0);
      idle(200);
      chk("b2b_accepts", 32'(acc_q.size() - a0), 32'h3);
      chk("b2b_byte0", acc_at(a0),     32'h55);
      chk("b2b_byte1", acc_at(a0 + 1), 32'hFF);
      chk("b2b_byte2", acc_at(a0 + 2), 32'h00);
      chk("b2b_flags", 32'((ferr_n - f0) + (ovr_n - o0)), 32'h0);

      // Overrun: second byte dropped while the first is still held.
      u_if.ready = 1'b0;
      a0 = acc_q.size(); o0 = ovr_n;
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b1, 0);
      start2 = start_cyc;
      idle(40);
      chk("ovr_valid_held", 32'(u_if.valid),   32'h1);
      chk("ovr_byte_held",  32'(u_if.rx_byte), 32'h11);
      chk("ovr_pulses",     32'(ovr_n - o0),   32'h1);
      chk("ovr_when",       32'(last_ovr_cyc - start2), 32'(LAT));
      u_if.ready = 1'b1;
      tick(1);
      chk("ovr_valid_drop", 32'(u_if.valid), 32'h0);
      chk("ovr_accepts",    32'(acc_q.size() - a0), 32'h1);
      chk("ovr_acc_byte",   acc_at(a0), 32'h11);

      // Reset mid-frame, with a byte pending so the clear is visible.
      u_if.ready = 1'b0;
      send_frame(8'h7E, 1'b1, 0);
      idle(40);
      chk("pre_rst_valid", 32'(u_if.valid),   32'h1);
      chk("pre_rst_byte",  32'(u_if.rx_byte), 32'h7E);
      f0 = ferr_n; o0 = ovr_n;
      fork
         send_frame(8'hC3, 1'b1, 0);
         begin
            tick(16 + 16 * 4 + 8);
            rst_n = 1'b0;
            #1;
            chk("rst_valid",   32'(u_if.valid),   32'h0);
            chk("rst_rx_byte", 32'(u_if.rx_byte), 32'h0);
            chk("rst_flags",   32'({frame_err, overrun}), 32'h0);
         end
      join
      tick(3);
      rst_n = 1'b1;
      u_if.ready = 1'b1;
      idle(5);
      a0 = acc_q.size();
      send_frame(8'h81, 1'b1, 0);
      idle(200);
      chk("post_rst_accepts", 32'(acc_q.size() - a0), 32'h1);
      chk("post_rst_byte",    acc_at(a0), 32'h81);
      chk("post_rst_flags",   32'((ferr_n - f0) + (ovr_n - o0)), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_rx_deserialise.md
Name: uart_rx_deserialise

Overview:
- Receive-side UART stage: consumes the serial bitstream produced by uart_tx_serialise (loopback or far end) and rebuilds parallel bytes.
- Runs entirely on the system clock, with an internal baud-rate counter and no derived clock.
- Delivers bytes over a valid/ready handshake to downstream logic, e.g. the audio control FIFO.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- STOP_BITS, 1, stop bits checked per frame.
- CLK_RATE, 12000000, clk frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- Derived: DIVISOR = CLK_RATE/BAUD_RATE (clk cycles per bit); HALF = DIVISOR/2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_bits  in  1  serial line, idle high, asynchronous to clk.
- rx_byte  out  DATA_BITS  received byte; stable while valid=1.
- valid  out  1  rx_byte holds an unconsumed byte.
- ready  in  1  downstream accepts rx_byte when valid&&ready.
- frame_err  out  1  one-cycle pulse: a stop-bit sample read 0.
- overrun  out  1  one-cycle pulse: a completed byte was dropped.

Behaviour:
- Reset (async assert, sync deassert to clk) values:
  - rx_byte=0, valid=0, frame_err=0, overrun=0.
  - Synchroniser flops=1, state=IDLE, all counters=0.
- rx_bits passes through a 2-flop synchroniser. All decisions use the synchronised bit rx_s, which adds 2 cycles of latency.
- Bit-timing counter: width $clog2(DIVISOR), wraps to 0 at DIVISOR-1.
- FSM states and transitions:
  - IDLE: rx_s==0 → START, timer=0.
  - START: at timer==HALF-1, sample rx_s. If 0 → DATA with timer=0 and bit_cnt=0. If 1 → IDLE, glitch rejected, no flags.
  - DATA: at timer==DIVISOR-1, sample rx_s into the shift register, inserting at the MSB and shifting right, so the first bit received becomes the LSB. Increment bit_cnt. After DATA_BITS samples → STOP.
  - STOP: at timer==DIVISOR-1, sample rx_s, once per stop bit. Any 0 sample → frame_err pulse next cycle, byte discarded, → BREAK. After the last stop bit samples 1 → deliver the byte, → IDLE.
  - BREAK: wait for rx_s==1, then → IDLE. This prevents a held-low line from being re-read as start bits.
- Sample points fall mid-bit: half a bit after the start edge, then every DIVISOR cycles.
- Delivery happens the cycle after the final stop sample:
  - valid=0, or valid&&ready in that same cycle: rx_byte ← shift register, valid=1.
  - valid=1 and ready=0: new byte dropped, rx_byte unchanged, overrun pulses for 1 cycle.
- Handshake:
  - valid deasserts the cycle after valid&&ready, unless a delivery occurs in that same cycle, in which case valid stays 1 with the new byte.
  - ready has no effect while valid=0.
- The FSM never stalls on ready. Reception continues regardless of downstream.
- Reset mid-frame aborts the frame: partial bits are lost and no flags are raised.
- Total latency from the start-bit falling edge to valid: 2 + HALF + (DATA_BITS+STOP_BITS)·DIVISOR + 1 cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One parity bit, even parity, is sampled between the last data bit and the first stop bit. This adds state PARITY.
  - Extra port parity_err (out, 1): one-cycle pulse when XOR of data bits ^ parity bit ≠ 0.
  - A byte with bad parity is discarded, not delivered. The stop bit is still checked.
  - If both parity and stop bit are bad, parity_err and frame_err pulse in their respective cycles.
  - Latency grows by DIVISOR.
- Undefined: no PARITY state and no parity_err port. The frame is exactly start + DATA_BITS + STOP_BITS.

Test Plan (bench uses CLK_RATE=1600000, BAUD_RATE=100000, so DIVISOR=16 and HALF=8):
- Drive frame for 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with ready=1 → valid pulses 1 cycle at 2+8+9·16+1=155 cycles after the start edge, rx_byte=0xA5, no flags.
- rx_bits low for 5 cycles, then high → no valid, FSM back in IDLE. A frame for 0x3C immediately after is received correctly.
- Frame 0x12 with the stop bit driven 0, line then held low for 40 cycles → frame_err pulses once, no valid, no second start detected until the line returns high.
- ready=0, send 0x11 then 0x22 back-to-back → valid=1 with rx_byte=0x11, overrun pulses at the 0x22 delivery point, rx_byte stays 0x11. Raise ready → valid drops next cycle.
- Back-to-back 0x55, 0xFF, 0x00 with ready=1, generated by uart_tx_serialise at the same parameters → three valid pulses, bytes in order, no flags.
- Assert rst_n=0 during bit 4 of a frame → all outputs 0 immediately. After release, a following frame 0x81 is received correctly.
